// File: rtl/decode_bundle_nw_if.sv
// Fetch-to-dispatch bundle interface for the N-wide decode stage.
// master = front end / dispatch side, slave = the decoder.
interface decode_bundle_nw_if #(
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned XLEN    = 32
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [ISSUE_W-1:0]        in_lane_vld;
  logic [32*ISSUE_W-1:0]     in_instr;
  logic [XLEN-1:0]           in_pc;

  logic                      out_valid;
  logic                      out_ready;
  logic [ISSUE_W-1:0]        out_lane_vld;
  logic [XLEN*ISSUE_W-1:0]   out_pc;
  logic [7*ISSUE_W-1:0]      out_opcode;
  logic [3*ISSUE_W-1:0]      out_func3;
  logic [7*ISSUE_W-1:0]      out_func7;
  logic [5*ISSUE_W-1:0]      out_rs1;
  logic [5*ISSUE_W-1:0]      out_rs2;
  logic [5*ISSUE_W-1:0]      out_rd;
  logic [ISSUE_W-1:0]        out_rd_en;
  logic [ISSUE_W-1:0]        out_rs1_en;
  logic [ISSUE_W-1:0]        out_rs2_en;
  logic [XLEN*ISSUE_W-1:0]   out_imm;
  logic [ISSUE_W-1:0]        out_illegal;
  logic [ISSUE_W-1:0]        out_dep_rs1;
  logic [ISSUE_W-1:0]        out_dep_rs2;

  modport master (
    output flush, in_valid, in_lane_vld, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_lane_vld, out_pc, out_opcode, out_func3, out_func7,
           out_rs1, out_rs2, out_rd, out_rd_en, out_rs1_en, out_rs2_en, out_imm,
           out_illegal, out_dep_rs1, out_dep_rs2
  );

  modport slave (
    input  flush, in_valid, in_lane_vld, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_lane_vld, out_pc, out_opcode, out_func3, out_func7,
           out_rs1, out_rs2, out_rd, out_rd_en, out_rs1_en, out_rs2_en, out_imm,
           out_illegal, out_dep_rs1, out_dep_rs2
  );
endinterface

// File: rtl/decode_bundle_nw.sv
// N-wide registered decode stage: per-lane field/immediate decode, intra-bundle RAW
// detection, and a 2-entry FIFO between fetch and dispatch.
module decode_bundle_nw #(
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned XLEN    = 32
) (
  input logic                clk,
  input logic                rst,
  decode_bundle_nw_if.slave  io_bus
);

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpS    = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpJ    = 7'b1101111;
  localparam logic [6:0] OpU    = 7'b0010111;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpLw   = 7'b0000011;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_en;
    logic            rs1_en;
    logic            rs2_en;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            dep_rs1;
    logic            dep_rs2;
  } lane_t;

  typedef lane_t [ISSUE_W-1:0] bundle_t;

  function automatic lane_t decode_lane(input logic [31:0]     ins,
                                        input logic            vld,
                                        input logic [XLEN-1:0] pc);
    lane_t              l;
    logic               is_r, is_i, is_s, is_b, is_j, is_u, is_jalr, is_lw, legal;
    logic signed [31:0] imm32;
    l         = '0;
    l.vld     = vld;
    l.pc      = pc;
    l.opcode  = ins[6:0];
    l.func3   = ins[14:12];
    l.func7   = ins[31:25];
    l.rs1     = ins[19:15];
    l.rs2     = ins[24:20];
    l.rd      = ins[11:7];
    is_r      = (ins[6:0] == OpR);
    is_i      = (ins[6:0] == OpI);
    is_s      = (ins[6:0] == OpS);
    is_b      = (ins[6:0] == OpB);
    is_j      = (ins[6:0] == OpJ);
    is_u      = (ins[6:0] == OpU);
    is_jalr   = (ins[6:0] == OpJalr);
    is_lw     = (ins[6:0] == OpLw);
    legal     = is_r | is_i | is_s | is_b | is_j | is_u | is_jalr | is_lw;
    l.illegal = vld & ~legal;
    l.rd_en   = vld & (is_r | is_i | is_u | is_j | is_jalr | is_lw) & (ins[11:7] != 5'd0);
    l.rs1_en  = vld & (is_r | is_i | is_s | is_b | is_jalr | is_lw);
    l.rs2_en  = vld & (is_r | is_s | is_b);
    case (ins[6:0])
      OpI, OpJalr, OpLw: imm32 = {{20{ins[31]}}, ins[31:20]};
      OpS:               imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OpB:               imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OpU:               imm32 = {ins[31:12], 12'b0};
      OpJ:               imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:           imm32 = '0;
    endcase
    // Signed cast widens with sign extension when XLEN > 32.
    l.imm = XLEN'(imm32);
    return l;
  endfunction

  bundle_t    w_dec;
  bundle_t    w_head;
  logic       w_push;
  logic       w_pop;
  logic       w_out_valid;
  logic       w_in_ready;

  bundle_t    r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      w_dec[i] = decode_lane(io_bus.in_instr[32*i +: 32], io_bus.in_lane_vld[i],
                             io_bus.in_pc + XLEN'(4 * i));
    end
    // Older lanes have lower indices; lane 0 never depends on anything in the bundle.
    for (int i = 1; i < ISSUE_W; i++) begin
      for (int j = 0; j < i; j++) begin
        if (w_dec[j].vld && w_dec[j].rd_en && (w_dec[j].rd == w_dec[i].rs1)) begin
          w_dec[i].dep_rs1 = w_dec[i].rs1_en;
        end
        if (w_dec[j].vld && w_dec[j].rd_en && (w_dec[j].rd == w_dec[i].rs2)) begin
          w_dec[i].dep_rs2 = w_dec[i].rs2_en;
        end
      end
    end
  end

  assign w_out_valid = (r_count != 2'd0);
  assign w_in_ready  = (r_count != 2'd2);
  assign w_push      = io_bus.in_valid & w_in_ready & ~io_bus.flush;
  assign w_pop       = w_out_valid & io_bus.out_ready & ~io_bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (io_bus.flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head           = r_mem[r_rd_ptr];
  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = w_out_valid;

  always_comb begin
    io_bus.out_lane_vld = '0;
    io_bus.out_pc       = '0;
    io_bus.out_opcode   = '0;
    io_bus.out_func3    = '0;
    io_bus.out_func7    = '0;
    io_bus.out_rs1      = '0;
    io_bus.out_rs2      = '0;
    io_bus.out_rd       = '0;
    io_bus.out_rd_en    = '0;
    io_bus.out_rs1_en   = '0;
    io_bus.out_rs2_en   = '0;
    io_bus.out_imm      = '0;
    io_bus.out_illegal  = '0;
    io_bus.out_dep_rs1  = '0;
    io_bus.out_dep_rs2  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      io_bus.out_lane_vld[i]          = w_head[i].vld & w_out_valid;
      io_bus.out_pc[XLEN*i +: XLEN]   = w_head[i].pc;
      io_bus.out_opcode[7*i +: 7]     = w_head[i].opcode;
      io_bus.out_func3[3*i +: 3]      = w_head[i].func3;
      io_bus.out_func7[7*i +: 7]      = w_head[i].func7;
      io_bus.out_rs1[5*i +: 5]        = w_head[i].rs1;
      io_bus.out_rs2[5*i +: 5]        = w_head[i].rs2;
      io_bus.out_rd[5*i +: 5]         = w_head[i].rd;
      io_bus.out_rd_en[i]             = w_head[i].rd_en;
      io_bus.out_rs1_en[i]            = w_head[i].rs1_en;
      io_bus.out_rs2_en[i]            = w_head[i].rs2_en;
      io_bus.out_imm[XLEN*i +: XLEN]  = w_head[i].imm;
      io_bus.out_illegal[i]           = w_head[i].illegal;
      io_bus.out_dep_rs1[i]           = w_head[i].dep_rs1;
      io_bus.out_dep_rs2[i]           = w_head[i].dep_rs2;
    end
  end

endmodule
